// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states and
// the byte-mask helper used by both the store path and the load aligner.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int MAX_RD_LATENCY = 4;

    function automatic logic [63:0] size_mask(input size_e size);
        logic [63:0] mask;
        unique case (size)
            SIZE_BYTE: mask = 64'h0000_0000_0000_00FF;
            SIZE_HALF: mask = 64'h0000_0000_0000_FFFF;
            SIZE_WORD: mask = 64'h0000_0000_FFFF_FFFF;
            default:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-data conditioning: shifts the addressed lanes down to bit 0, truncates to
// the access size and sign- or zero-extends the result.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OFF  = $clog2(NB_DATA / 8)
) (
    input  size_e                size_i,
    input  logic                 signed_i,
    input  logic [NB_OFF-1:0]    off_i,
    input  logic [NB_DATA-1:0]   raw_i,
    output logic [NB_DATA-1:0]   data_o
);

    logic [NB_DATA-1:0] shifted;
    logic [NB_DATA-1:0] mask;
    logic               msb;

    always_comb begin
        shifted = raw_i >> {off_i, 3'b000};
        mask    = NB_DATA'(size_mask(size_i));
        // Full-width accesses get msb = 0 so the upper fill is never applied.
        unique case (size_i)
            SIZE_BYTE: msb = shifted[7];
            SIZE_HALF: msb = shifted[15];
            SIZE_WORD: msb = (NB_DATA > 32) ? shifted[31] : 1'b0;
            default:   msb = 1'b0;
        endcase
        data_o = (shifted & mask) | ((signed_i && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage request/response engine: one load or store per handshake, lane
// strobes from the low address bits, synchronous BRAM with RD_LATENCY read delay.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 12,
    parameter int RD_LATENCY = 1,
    parameter int NB_STRB    = NB_DATA / 8,
    parameter int NB_OFF     = $clog2(NB_DATA / 8)
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic                      i_req_signed,
    input  logic [1:0]                i_req_size,
    input  logic [NB_ADDR-1:0]        i_req_addr,
    input  logic [NB_DATA-1:0]        i_req_wdata,
    output logic                      o_rsp_valid,
    output logic [NB_DATA-1:0]        o_rsp_rdata,
    output logic                      o_rsp_error,
    output logic                      o_mem_en,
    output logic [NB_STRB-1:0]        o_mem_we,
    output logic [NB_ADDR-NB_OFF-1:0] o_mem_addr,
    output logic [NB_DATA-1:0]        o_mem_wdata,
    input  logic [NB_DATA-1:0]        i_mem_rdata
);

    state_e                      state_q, state_d;
    logic                        write_q, write_d;
    logic                        sign_q, sign_d;
    size_e                       size_q, size_d;
    logic [NB_OFF-1:0]           off_q, off_d;
    logic                        err_q, err_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [NB_DATA-1:0]          rdata_q, rdata_d;
    logic                        mem_en_q, mem_en_d;
    logic [NB_STRB-1:0]          mem_we_q, mem_we_d;
    logic [NB_ADDR-NB_OFF-1:0]   mem_addr_q, mem_addr_d;
    logic [NB_DATA-1:0]          mem_wdata_q, mem_wdata_d;

    size_e                       req_size;
    logic [NB_OFF-1:0]           req_off;
    logic                        req_err;
    logic                        accept;
    logic                        last_wait;
    logic [NB_DATA-1:0]          load_data;

    function automatic logic is_error(input size_e size, input logic [NB_OFF-1:0] off);
        logic err;
        unique case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = off[0];
            SIZE_WORD: err = |off[1:0];
            default:   err = (NB_DATA == 32) ? 1'b1 : (|off);
        endcase
        return err;
    endfunction

    function automatic logic [NB_STRB-1:0] base_strobe(input size_e size);
        logic [NB_STRB-1:0] strb;
        unique case (size)
            SIZE_BYTE: strb = NB_STRB'(4'b0001);
            SIZE_HALF: strb = NB_STRB'(4'b0011);
            SIZE_WORD: strb = NB_STRB'(4'b1111);
            default:   strb = '1;
        endcase
        return strb;
    endfunction

    always_comb begin
        req_size  = size_e'(i_req_size);
        req_off   = i_req_addr[NB_OFF-1:0];
        req_err   = is_error(req_size, req_off);
        accept    = i_req_valid && (state_q == IDLE);
        last_wait = (cnt_q == 2'(RD_LATENCY - 1));
    end

    mem_lane_align #(
        .NB_DATA (NB_DATA),
        .NB_OFF  (NB_OFF)
    ) u_lane_align (
        .size_i   (size_q),
        .signed_i (sign_q),
        .off_i    (off_q),
        .raw_i    (i_mem_rdata),
        .data_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        sign_d      = sign_q;
        size_d      = size_q;
        off_d       = off_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = i_req_write;
                    sign_d  = i_req_signed;
                    size_d  = req_size;
                    off_d   = req_off;
                    err_d   = req_err;
                    rdata_d = '0;
                    state_d = req_err ? RESP : ACCESS;
                    // Memory port registers load here so they are live exactly in ACCESS.
                    if (!req_err) begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = i_req_addr[NB_ADDR-1:NB_OFF];
                        if (i_req_write) begin
                            mem_we_d    = base_strobe(req_size) << req_off;
                            mem_wdata_d = (i_req_wdata & NB_DATA'(size_mask(req_size)))
                                          << {req_off, 3'b000};
                        end
                    end
                end
            end
            ACCESS: begin
                cnt_d   = 2'd0;
                state_d = write_q ? RESP : WAIT;
            end
            WAIT: begin
                if (last_wait) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (cnt_q != 2'd3) begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= SIZE_BYTE;
            off_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= 2'd0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            sign_q      <= sign_d;
            size_q      <= size_d;
            off_q       <= off_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_rsp_valid = (state_q == RESP);
        o_rsp_error = (state_q == RESP) && err_q;
        o_rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        o_mem_en    = mem_en_q;
        o_mem_we    = mem_we_q;
        o_mem_addr  = mem_addr_q;
        o_mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) share one
// request stream; a transaction-level model predicts every output each cycle.
module tb_mem_access_unit;

    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [11:0] req_addr = 12'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];
    logic        mem_en    [2];
    logic [3:0]  mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] mem     [2][1024];
    logic [31:0] rd_pipe [2][4];
    logic        bd_en = 1'b0;
    logic [9:0]  bd_addr = 10'd0;
    logic [31:0] bd_data = 32'd0;

    int          left      [2] = '{0, 0};
    logic        mem_now   [2] = '{1'b0, 1'b0};
    logic        sv_err    [2];
    logic [31:0] sv_rdata  [2];
    logic [3:0]  sv_we     [2];
    logic [9:0]  sv_addr   [2];
    logic [31:0] sv_wdata  [2];
    logic        exp_ready [2] = '{1'b1, 1'b1};
    logic        exp_valid [2] = '{1'b0, 1'b0};
    logic        exp_err   [2] = '{1'b0, 1'b0};
    logic [31:0] exp_rdata [2] = '{32'd0, 32'd0};
    logic        exp_en    [2] = '{1'b0, 1'b0};
    logic [3:0]  exp_we    [2] = '{4'd0, 4'd0};
    logic [9:0]  exp_addr  [2] = '{10'd0, 10'd0};
    logic [31:0] exp_wdata [2] = '{32'd0, 32'd0};

    int nchecks = 0;
    int nerrs   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_unit #(
            .NB_DATA    (32),
            .NB_ADDR    (12),
            .RD_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .i_clock      (clk),
            .i_reset_n    (rst_n),
            .i_req_valid  (req_valid),
            .o_req_ready  (req_ready[g]),
            .i_req_write  (req_write),
            .i_req_signed (req_signed),
            .i_req_size   (req_size),
            .i_req_addr   (req_addr),
            .i_req_wdata  (req_wdata),
            .o_rsp_valid  (rsp_valid[g]),
            .o_rsp_rdata  (rsp_rdata[g]),
            .o_rsp_error  (rsp_error[g]),
            .o_mem_en     (mem_en[g]),
            .o_mem_we     (mem_we[g]),
            .o_mem_addr   (mem_addr[g]),
            .o_mem_wdata  (mem_wdata[g]),
            .i_mem_rdata  (mem_rdata[g])
        );
        assign mem_rdata[g] = rd_pipe[g][(g == 0) ? 0 : 2];
    end

    // BRAM: read-first, output delayed through a pipe; idle slots carry junk.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (bd_en) mem[g][bd_addr] <= bd_data;
            if (mem_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[g][b]) mem[g][mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                rd_pipe[g][0] <= mem[g][mem_addr[g]];
            end else begin
                rd_pipe[g][0] <= 32'hDEAD_BEEF;
            end
            for (int s = 1; s < 4; s++) rd_pipe[g][s] <= rd_pipe[g][s-1];
        end
    end

    // Transaction model: each accepted request occupies the unit for D cycles
    // (1 error, 2 store, LAT+2 load); the response is the last of them.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int          nb;
            int          off;
            logic        acc;
            logic        bad;
            logic [31:0] msk;
            logic [31:0] word;
            logic [31:0] val;
            if (!rst_n) begin
                left[g]    = 0;
                mem_now[g] = 1'b0;
            end else begin
                acc = (left[g] == 0) && req_valid;
                if (left[g] > 0) left[g] = left[g] - 1;
                mem_now[g] = 1'b0;
                if (acc) begin
                    nb   = 1 << req_size;
                    off  = int'(req_addr[1:0]);
                    msk  = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                    bad  = (req_size == 2'd3) || ((int'(req_addr) % nb) != 0);
                    word = mem[g][req_addr[11:2]] >> (8 * off);
                    val  = word & msk;
                    if (req_signed && nb < 4 && word[8*nb-1]) val = val | ~msk;
                    sv_err[g]   = bad;
                    sv_rdata[g] = (req_write || bad) ? 32'd0 : val;
                    sv_we[g]    = req_write ? 4'(((1 << nb) - 1) << off) : 4'd0;
                    sv_addr[g]  = req_addr[11:2];
                    sv_wdata[g] = req_write ? ((req_wdata & msk) << (8 * off)) : 32'd0;
                    mem_now[g]  = !bad;
                    left[g]     = bad ? 1 : (req_write ? 2 : LAT[g] + 2);
                end
            end
            exp_ready[g] = (left[g] == 0);
            exp_valid[g] = (left[g] == 1);
            exp_err[g]   = exp_valid[g] && sv_err[g];
            exp_rdata[g] = exp_valid[g] ? sv_rdata[g] : 32'd0;
            exp_en[g]    = mem_now[g];
            exp_we[g]    = mem_now[g] ? sv_we[g] : 4'd0;
            exp_addr[g]  = mem_now[g] ? sv_addr[g] : 10'd0;
            exp_wdata[g] = mem_now[g] ? sv_wdata[g] : 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerrs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            logic live;
            live = rst_n;
            chk($sformatf("g%0d req_ready", g), 32'(req_ready[g]), live ? 32'(exp_ready[g]) : 32'd1);
            chk($sformatf("g%0d rsp_valid", g), 32'(rsp_valid[g]), live ? 32'(exp_valid[g]) : 32'd0);
            chk($sformatf("g%0d rsp_error", g), 32'(rsp_error[g]), live ? 32'(exp_err[g]) : 32'd0);
            chk($sformatf("g%0d rsp_rdata", g), rsp_rdata[g], live ? exp_rdata[g] : 32'd0);
            chk($sformatf("g%0d mem_en", g), 32'(mem_en[g]), live ? 32'(exp_en[g]) : 32'd0);
            chk($sformatf("g%0d mem_we", g), 32'(mem_we[g]), live ? 32'(exp_we[g]) : 32'd0);
            chk($sformatf("g%0d mem_addr", g), 32'(mem_addr[g]), live ? 32'(exp_addr[g]) : 32'd0);
            chk($sformatf("g%0d mem_wdata", g), mem_wdata[g], live ? exp_wdata[g] : 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_req(input logic w, input logic s, input logic [1:0] sz,
                          input logic [11:0] a, input logic [31:0] d);
        req_write  = w;
        req_signed = s;
        req_size   = sz;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        tick();
        bd_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_ready[0] && exp_ready[1]) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            nchecks++;
            nerrs++;
            $display("FAIL idle_timeout: unit still busy after %0d cycles", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nrsp;

        // Reset state, and a request presented during reset is ignored.
        tick();
        chk("reset ready", 32'(req_ready[0]), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset mem_en", 32'(mem_en[1]), 32'd0);
        req_write = 1'b1; req_size = 2'd2; req_addr = 12'h010; req_wdata = 32'h1111_1111;
        req_valid = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Byte store at 0x006.
        do_req(1'b1, 1'b0, 2'd0, 12'h006, 32'h1234_56A5);
        chk("sb mem_en", 32'(mem_en[0]), 32'd1);
        chk("sb mem_addr", 32'(mem_addr[0]), 32'h001);
        chk("sb mem_we", 32'(mem_we[0]), 32'b0100);
        chk("sb mem_wdata", mem_wdata[0], 32'h00A5_0000);
        tick();
        chk("sb rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("sb rsp_error", 32'(rsp_error[0]), 32'd0);
        wait_idle();

        // Half loads, signed and unsigned.
        backdoor(10'd0, 32'h8001_7FFF);
        do_req(1'b0, 1'b1, 2'd1, 12'h002, 32'd0);
        tick();
        tick();
        chk("lh signed valid", 32'(rsp_valid[0]), 32'd1);
        chk("lh signed rdata", rsp_rdata[0], 32'hFFFF_8001);
        wait_idle();
        do_req(1'b0, 1'b0, 2'd1, 12'h002, 32'd0);
        tick();
        tick();
        chk("lhu rdata", rsp_rdata[0], 32'h0000_8001);
        wait_idle();

        // Signed byte and plain word loads.
        backdoor(10'd0, 32'h80FF_FFFF);
        backdoor(10'd1, 32'h80FF_FFFF);
        do_req(1'b0, 1'b1, 2'd0, 12'h003, 32'd0);
        tick();
        tick();
        chk("lb signed rdata", rsp_rdata[0], 32'hFFFF_FF80);
        wait_idle();
        do_req(1'b0, 1'b1, 2'd2, 12'h004, 32'd0);
        tick();
        tick();
        chk("lw rdata", rsp_rdata[0], 32'h80FF_FFFF);
        wait_idle();

        // Misaligned word store and illegal size 3.
        do_req(1'b1, 1'b0, 2'd2, 12'h005, 32'hFFFF_FFFF);
        chk("sw misaligned valid", 32'(rsp_valid[0]), 32'd1);
        chk("sw misaligned error", 32'(rsp_error[1]), 32'd1);
        chk("sw misaligned rdata", rsp_rdata[0], 32'd0);
        chk("sw misaligned mem_en", 32'(mem_en[0]), 32'd0);
        wait_idle();
        do_req(1'b0, 1'b0, 2'd3, 12'h000, 32'd0);
        chk("size3 error", 32'(rsp_error[0]), 32'd1);
        wait_idle();

        // Further patterns checked by the model only.
        do_req(1'b1, 1'b0, 2'd1, 12'h00A, 32'hCAFE_BEEF);
        chk("sh mem_we", 32'(mem_we[0]), 32'b1100);
        chk("sh mem_wdata", mem_wdata[0], 32'hBEEF_0000);
        wait_idle();
        do_req(1'b1, 1'b0, 2'd0, 12'h00F, 32'h0000_0081);
        wait_idle();
        do_req(1'b0, 1'b1, 2'd0, 12'h00F, 32'd0);
        wait_idle();
        do_req(1'b0, 1'b0, 2'd2, 12'h008, 32'd0);
        wait_idle();
        do_req(1'b0, 1'b1, 2'd1, 12'h003, 32'd0);
        wait_idle();
        do_req(1'b1, 1'b0, 2'd2, 12'h020, 32'h0BAD_F00D);
        wait_idle();
        do_req(1'b0, 1'b1, 2'd1, 12'h020, 32'd0);
        wait_idle();

        // Back-to-back word loads with valid held high (latency-3 instance).
        req_write = 1'b0; req_signed = 1'b0; req_size = 2'd2; req_addr = 12'h004;
        req_valid = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("b2b ready T+%0d", k), 32'(req_ready[1]), 32'd0);
            chk($sformatf("b2b rsp_valid T+%0d", k), 32'(rsp_valid[1]), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) chk("b2b rdata", rsp_rdata[1], 32'h80FF_FFFF);
            if (k < 5) tick();
        end
        tick();
        chk("b2b ready T+6", 32'(req_ready[1]), 32'd1);
        tick();
        chk("b2b second accept", 32'(mem_en[1]), 32'd1);
        req_valid = 1'b0;
        wait_idle();

        // Reset pulse while both instances wait on the BRAM.
        do_req(1'b0, 1'b0, 2'd2, 12'h004, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst ready", 32'(req_ready[1]), 32'd1);
        chk("rst mem_en", 32'(mem_en[0]), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid[0] || rsp_valid[1]) nrsp++;
        end
        chk("no rsp after reset", 32'(nrsp), 32'd0);
        do_req(1'b0, 1'b0, 2'd2, 12'h000, 32'd0);
        tick();
        tick();
        chk("post-reset lat1 valid", 32'(rsp_valid[0]), 32'd1);
        chk("post-reset lat1 rdata", rsp_rdata[0], 32'h80FF_FFFF);
        tick();
        tick();
        chk("post-reset lat3 valid", 32'(rsp_valid[1]), 32'd1);
        chk("post-reset lat3 rdata", rsp_rdata[1], 32'h80FF_FFFF);
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential, parametrised data-memory access unit for the MEM stage. It replaces the purely combinational size/sign data conditioning with a full request/response engine. It accepts one load or store per transaction over a valid/ready handshake, derives byte-lane strobes from the low address bits, and drives a synchronous data BRAM with configurable read latency. Load data is lane-aligned and sign- or zero-extended; misaligned and illegal accesses are flagged without touching memory.

## Interface
Parameters:
- NB_DATA, 32, data width; 32 or 64 only.
- NB_ADDR, 12, byte-address width.
- RD_LATENCY, 1, BRAM read latency in cycles (1–4).
- NB_STRB, NB_DATA/8, byte lanes (derived).
- NB_OFF, log2(NB_STRB), lane-offset bits (derived).

Ports:
- i_clock  in  1  single clock; everything is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept; high only in IDLE.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_signed  in  1  sign-extend load result.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when NB_DATA = 64).
- i_req_addr  in  NB_ADDR  byte address.
- i_req_wdata  in  NB_DATA  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure.
- o_rsp_rdata  out  NB_DATA  extended load data; 0 for stores and errors.
- o_rsp_error  out  1  misaligned or illegal size; qualified by o_rsp_valid.
- o_mem_en  out  1  BRAM enable.
- o_mem_we  out  NB_STRB  per-lane write enable.
- o_mem_addr  out  NB_ADDR-NB_OFF  word address (i_req_addr >> NB_OFF).
- o_mem_wdata  out  NB_DATA  lane-shifted store data.
- i_mem_rdata  in  NB_DATA  BRAM read data, valid RD_LATENCY cycles after the o_mem_en cycle.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE → RESP on an accepted error request.
  - IDLE → ACCESS on any other accepted request.
  - ACCESS → RESP for stores.
  - ACCESS → WAIT for loads.
  - WAIT → RESP when the latency counter reaches RD_LATENCY−1.
  - RESP → IDLE unconditionally.
- Accept condition: i_req_valid & o_req_ready. All request fields are registered at accept; later input changes are ignored.
- Lane offset: off = i_req_addr[NB_OFF-1:0].
- Base strobes: byte 0b1, half 0b11, word 0xF, dword all-ones. The strobe is the base shifted left by off.
- Store data: i_req_wdata masked to the access size, then shifted left by off*8. Unused lanes are 0.
- Load data: i_mem_rdata >> off*8, truncated to the access size, then:
  - extended with the MSB of the truncated value if signed, otherwise zero-filled;
  - for word on NB_DATA = 32 and for dword, passed through and i_req_signed is ignored.
- Error conditions:
  - half with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - dword with addr[2:0] ≠ 0;
  - size 3 when NB_DATA = 32.
- Error response: o_mem_en is never asserted, o_rsp_rdata = 0, o_rsp_error = 1.
- o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata are registered. They are non-zero only in ACCESS and are 0 in every other state.
- Load result is captured into a register at the end of the last WAIT cycle.

## Timing
- Accept at cycle T.
  - Error: o_rsp_valid at T+1.
  - Store: memory write in T+1, o_rsp_valid at T+2.
  - Load: o_mem_en at T+1, o_rsp_valid at T+2+RD_LATENCY.
- o_req_ready returns high the cycle after RESP. Maximum throughput is one transaction per 3 cycles (store) or RD_LATENCY+3 cycles (load).
- i_req_valid held high during busy is not accepted. It is accepted on the first IDLE cycle.
- Reset values: state IDLE, o_req_ready 1, all other outputs 0. Requests presented while i_reset_n = 0 are ignored.
- Reset mid-operation forces outputs to 0 immediately:
  - an asserting o_mem_we is dropped;
  - a pending response is discarded, with no o_rsp_valid after release.
- The latency counter is 2 bits. It clears on entry to WAIT and does not wrap.

## Structure
- Shared package mem_access_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD;
  - the FSM state encoding;
  - the maximum RD_LATENCY constant.
- One combinational sub-module, mem_lane_align, takes (size, signed, off, raw data) and produces the extended result. The FSM stays in the top module.

## Test plan
- NB_DATA = 32, RD_LATENCY = 1. Store byte, addr 0x006, wdata 0x123456A5 → at T+1: mem_addr 0x001, we 0b0100, wdata 0x00A50000. At T+2: rsp_valid, error 0.
- Signed half load, addr 0x002, i_mem_rdata 0x80017FFF → rsp_rdata 0xFFFF8001 at T+3. The same load unsigned → 0x00008001.
- Signed byte load, addr 0x003, i_mem_rdata 0x80FFFFFF → 0xFFFFFF80. Word load, addr 0x004 → raw 0x80FFFFFF.
- Word store, addr 0x005 → rsp_valid at T+1, error 1, rdata 0, o_mem_en never high. Size 3 on NB_DATA = 32 → same behaviour.
- RD_LATENCY = 3, word load with i_req_valid held high for a back-to-back second request → first rsp at T+5, o_req_ready low T+1..T+5, second accept at T+6.
- i_reset_n pulsed low during WAIT → all outputs 0 within the reset cycle, no rsp_valid follows. A request after release completes with the nominal latency.
